// File: rtl/tick_timer_arb_if.sv
// tick_timer_arb_if: request/grant/timer bundle shared by the requesters and the timer arbiter.
interface tick_timer_arb_if #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   tick;
  logic [N_REQ-1:0]       done;
  modport master (output req, len, input gnt, busy, tick, done);
  modport slave  (input req, len, output gnt, busy, tick, done);
endinterface

// File: rtl/tick_timer_arb.sv
// tick_timer_arb: one prescaled interval timer shared by N_REQ requesters.
// TICK_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module tick_timer_arb #(
  parameter int N_REQ    = 3,
  parameter int PRESCALE = 50000000,
  parameter int PRE_W    = 26,
  parameter int CNT_W    = 8
)(
  input logic             clk,
  input logic             rst,
  tick_timer_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_rem;
  logic [IDX_W-1:0] r_win;
  logic [IDX_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;
  logic             r_tick;
  logic [IDX_W-1:0] w_win;
  logic [CNT_W-1:0] w_len;
  assign w_len    = bus.len[int'(r_win)*CNT_W +: CNT_W];
  assign bus.gnt  = r_gnt;
  assign bus.busy = r_busy;
  assign bus.tick = r_tick;
  assign bus.done = r_done;
  // lowest set request overall, overridden by the lowest one at or after r_ptr
  always_comb begin
    w_win = '0;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (bus.req[j]) w_win = IDX_W'(j);
    for (int j = N_REQ - 1; j >= 0; j--)
      if (bus.req[j] && IDX_W'(j) >= r_ptr) w_win = IDX_W'(j);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= '0;
      r_pre   <= '0;
      r_rem   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
    end else begin
      r_tick <= 1'b0;
      r_done <= '0;
      if (r_state == S_DONE || (r_state != S_IDLE && !bus.req[r_win])) begin
        r_state <= S_IDLE;
        r_gnt   <= '0;
        r_busy  <= 1'b0;
`ifdef TICK_ARB_RR_EN
        r_ptr   <= (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;
`endif
      end else if (r_state == S_IDLE) begin
        if (|bus.req) begin
          r_win   <= w_win;
          r_gnt   <= N_REQ'(1) << w_win;
          r_busy  <= 1'b1;
          r_state <= S_LOAD;
        end
      end else if (r_state == S_LOAD) begin
        r_rem   <= w_len;
        r_pre   <= '0;
        r_state <= (w_len == '0) ? S_DONE : S_RUN;
        r_done  <= (w_len == '0) ? r_gnt : '0;
      end else if (r_pre == PRE_W'(PRESCALE - 1)) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
        r_rem  <= r_rem - 1'b1;
        if (r_rem == CNT_W'(1)) begin
          r_done  <= r_gnt;
          r_state <= S_DONE;
        end
      end else
        r_pre <= r_pre + 1'b1;
    end
endmodule
